if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage holding the architectural PC register, directly upstream of the next-PC logic.
- Drives the current PC to the NPC block and fetches the word at PC over a req/ack instruction-memory handshake.
- Presents the fetched instruction to decode with a valid/ready handshake.
- On retirement (decode accepts the instruction), loads the PC from the NPC block's result.
- Error detection: misaligned next-PC and memory timeout.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum FETCH cycles without imem_ack before bus error; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_o  out  32  current PC; feeds NPC block PC input.
- npc_i  in  32  next PC returned by NPC block for the current instruction.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; always equals pc_o.
- imem_ack  in  1  memory has data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst_valid  out  1  inst_o/inst_pc_o hold a fetched instruction.
- inst_ready  in  1  decode/execute accepts (retires) the instruction.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  32  PC of inst_o.
- retired_cnt  out  32  count of accepted instructions; wraps modulo 2^32.
- misalign_err  out  1  sticky; next PC had nonzero bits [1:0].
- bus_err  out  1  sticky; fetch timed out.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, pc_o=RESET_PC, inst_o=0, inst_pc_o=0, retired_cnt=0, both error flags=0, timer=0.
  - While in IDLE: imem_req=0, inst_valid=0.
- Reset mid-operation (any state) aborts everything; an imem_ack arriving in the reset cycle is ignored.
- States IDLE, FETCH, VALID, ERR; encoding 2 bits.
- Outputs are decoded from registered state, no combinational input-to-output paths except imem_addr=pc_o:
  - imem_req = (state==FETCH).
  - inst_valid = (state==VALID).
- IDLE: unconditionally -> FETCH next edge. First request therefore appears one cycle after reset release.
- FETCH:
  - imem_req=1, address held stable until ack.
  - If imem_ack: inst_o<=imem_rdata, inst_pc_o<=pc_o, timer<=0, -> VALID.
  - Else timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no ack, the next edge goes to ERR and sets bus_err.
  - Ack in the same cycle as the limit: ack wins, no error.
  - Zero-wait-state memory (ack in first FETCH cycle) is legal.
- VALID:
  - inst_valid=1; inst_o and inst_pc_o held stable.
  - When inst_ready=1:
    - pc_o<=npc_i.
    - retired_cnt<=retired_cnt+1.
    - If npc_i[1:0]!=2'b00: misalign_err<=1, -> ERR. pc_o still takes npc_i for debug visibility.
    - Else -> FETCH.
  - When inst_ready=0: stay in VALID, no change.
- Throughput: minimum 2 cycles per instruction (FETCH 1 + VALID 1); no prefetch.
- ERR: imem_req=0, inst_valid=0, all registers frozen; exit only by rst.
- npc_i is sampled only on the accepting edge; its value at other times is don't-care.
- PC arithmetic is 32-bit unsigned; no overflow detection (0xFFFF_FFFC -> 0 via NPC is legal).

Decomposition:
- Shared header/package holds:
  - state encodings: IDLE=2'd0, FETCH=2'd1, VALID=2'd2, ERR=2'd3.
  - default RESET_PC constant.
  - error-flag bit positions, for a future status register.
- One natural sub-module: fetch_timer.
  - Parameterised down-counter/comparator.
  - Inputs: clear, enable. Output: expired.
  - Instantiated once for the timeout.

Test Plan:
- Reset release -> next cycle imem_req=1, imem_addr=32'h0000_3000, inst_valid=0, retired_cnt=0.
- ack after 3 wait cycles with rdata=32'h2408_0005, inst_ready=1, npc_i=32'h0000_3004 -> inst_o=32'h2408_0005 and inst_pc_o=32'h0000_3000 while valid; pc_o=32'h0000_3004; retired_cnt=1.
- Hold inst_ready=0 for 5 cycles in VALID -> inst_valid and inst_o stable, pc_o unchanged, no new imem_req.
- Jump: npc_i=32'h0040_0010 at accept -> next imem_addr=32'h0040_0010.
- Misalign: npc_i=32'h0000_3006 at accept -> misalign_err=1 and pc_o=32'h0000_3006 in ERR; imem_req stays 0 until rst.
- Timeout cases:
  - No ack for 16 FETCH cycles -> bus_err=1, imem_req=0.
  - Ack on cycle 16 exactly -> no error.
  - rst asserted in VALID -> pc_o=32'h0000_3000, flags and retired_cnt cleared.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t            : fetch FSM state encoding (2 bits)
//   RESET_PC_DEFAULT   : default architectural PC after reset
//   ERR_BIT_MISALIGN   : bit position of the misalign flag in err_flags
//   ERR_BIT_BUS        : bit position of the bus-timeout flag in err_flags
package if_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   localparam int ERR_BIT_MISALIGN = 0;
   localparam int ERR_BIT_BUS      = 1;

endpackage

// File: rtl/if_fetch_timer.sv
// Fetch timeout timer: down-counter loaded with TIMEOUT_CYCLES-1.
// Counting down from the load value is the same as counting up from 0:
// expired is high once the equivalent up-count has reached
// TIMEOUT_CYCLES-1.
//   clk, rst  : clock, synchronous active-high reset (reloads counter)
//   clear     : reload counter (elapsed count back to 0)
//   enable    : count one elapsed cycle
//   expired   : elapsed count has reached TIMEOUT_CYCLES-1
module fetch_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LOAD = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= LOAD;
      end else if (enable && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign expired = (cnt == 8'd0);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage holding the architectural PC.
//   clk, rst                 : clock, synchronous active-high reset
//   pc_o                     : current PC, to the NPC block
//   npc_i                    : next PC from the NPC block (sampled on accept)
//   imem_req/addr/ack/rdata  : instruction-memory handshake
//   inst_valid/ready         : handshake to decode; accept == retire
//   inst_o, inst_pc_o        : fetched instruction and its PC
//   retired_cnt              : accepted-instruction count (wraps)
//   misalign_err, bus_err    : sticky error flags, cleared only by rst
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | imem_req high, waiting for ack or timeout
// VALID | instruction presented to decode, waiting for inst_ready
// ERR   | misaligned next-PC or bus timeout; frozen until rst
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_o,
   input  logic [31:0] npc_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic [31:0] retired_cnt,
   output logic        misalign_err,
   output logic        bus_err
);

   state_t      state, state_nxt;
   logic [1:0]  err_flags;
   logic        tmr_expired;
   logic        fetch_done;
   logic        accept;
   logic        npc_misaligned;

   assign fetch_done     = (state == FETCH) && imem_ack;
   assign accept         = (state == VALID) && inst_ready;
   assign npc_misaligned = (npc_i[1:0] != 2'b00);

   fetch_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (fetch_done),
      .enable  ((state == FETCH) && !imem_ack),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            // ack beats a timeout landing in the same cycle
            if (imem_ack) begin
               state_nxt = VALID;
            end else if (tmr_expired) begin
               state_nxt = ERR;
            end
         end
         VALID: begin
            if (inst_ready) begin
               state_nxt = npc_misaligned ? ERR : FETCH;
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_o        <= RESET_PC;
         inst_o      <= 32'd0;
         inst_pc_o   <= 32'd0;
         retired_cnt <= 32'd0;
         err_flags   <= 2'b00;
      end else begin
         if (fetch_done) begin
            inst_o    <= imem_rdata;
            inst_pc_o <= pc_o;
         end else if ((state == FETCH) && tmr_expired) begin
            err_flags[ERR_BIT_BUS] <= 1'b1;
         end
         if (accept) begin
            // a misaligned target is still loaded so it is visible in ERR
            pc_o        <= npc_i;
            retired_cnt <= retired_cnt + 32'd1;
            if (npc_misaligned) begin
               err_flags[ERR_BIT_MISALIGN] <= 1'b1;
            end
         end
      end
   end

   assign imem_req     = (state == FETCH);
   assign inst_valid   = (state == VALID);
   assign imem_addr    = pc_o;
   assign misalign_err = err_flags[ERR_BIT_MISALIGN];
   assign bus_err      = err_flags[ERR_BIT_BUS];

endmodule
